// File: rtl/fmul_operand_master.sv
// fmul_operand_master
// Initiator on the FP multiplier operand/result bus. It accepts one job
// (two single-precision operands) from a local requester and sends A, then B,
// over the shared 32-bit operand bus with a ready/accept four-phase handshake.
// It then pulses start, waits for resultready, captures the product and
// completes the result handshake with resultaccept. A watchdog aborts the job
// if any single responder event takes TIMEOUT cycles.
module fmul_operand_master #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned TW      = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  output logic [31:0] Tempbus,
  output logic        ready,
  input  logic        accept,
  output logic        start,
  input  logic        doneMul,
  input  logic        resultready,
  input  logic [31:0] ResultBus,
  output logic        resultaccept,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        res_zero,
  output logic        res_inf,
  output logic        res_nan,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    REL_A,
    SEND_B,
    REL_B,
    START,
    WAIT_RES,
    ACK_RES
  } state_t;

  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  logic [31:0]   job_b;
  logic [TW-1:0] wd_cnt;

  logic waiting;
  logic progress;
  logic abort;

  // doneMul is a status input only; it never influences the sequence.
  logic unused_done;
  assign unused_done = doneMul;

  // Identify the states that wait on the responder and whether the awaited
  // event is present this cycle; the watchdog aborts only when it is not.
  always_comb begin
    waiting  = 1'b0;
    progress = 1'b0;
    unique case (state)
      SEND_A, SEND_B: begin
        waiting  = 1'b1;
        progress = ready & accept;
      end
      REL_A, REL_B: begin
        waiting  = 1'b1;
        progress = ~accept;
      end
      WAIT_RES: begin
        waiting  = 1'b1;
        progress = resultready;
      end
      ACK_RES: begin
        waiting  = 1'b1;
        progress = ~resultready;
      end
      default: begin
        waiting  = 1'b0;
        progress = 1'b0;
      end
    endcase
    abort = waiting & ~progress & (wd_cnt == WD_LAST);
  end

  // Job sequencer, bus handshakes, result capture and watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      job_b        <= '0;
      wd_cnt       <= '0;
      req_ready    <= 1'b0;
      Tempbus      <= '0;
      ready        <= 1'b0;
      start        <= 1'b0;
      resultaccept <= 1'b0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_zero     <= 1'b0;
      res_inf      <= 1'b0;
      res_nan      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      res_valid <= 1'b0;

      if (!waiting || progress) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + TW'(1);
      end

      unique case (state)
        IDLE: begin
          if (req_ready && req_valid) begin
            // Tempbus itself carries A for the whole A phase, so only B
            // needs a separate job register.
            job_b       <= req_b;
            Tempbus     <= req_a;
            ready       <= ~accept;
            req_ready   <= 1'b0;
            timeout_err <= 1'b0;
            state       <= SEND_A;
          end else begin
            req_ready <= 1'b1;
            Tempbus   <= '0;
          end
        end

        SEND_A: begin
          if (progress) begin
            ready <= 1'b0;
            state <= REL_A;
          end else if (!accept) begin
            // A stale accept left over from an aborted job delays the rise.
            ready <= 1'b1;
          end
        end

        REL_A: begin
          if (progress) begin
            Tempbus <= job_b;
            ready   <= 1'b1;
            state   <= SEND_B;
          end
        end

        SEND_B: begin
          if (progress) begin
            ready <= 1'b0;
            state <= REL_B;
          end else if (!accept) begin
            ready <= 1'b1;
          end
        end

        REL_B: begin
          if (progress) begin
            start <= 1'b1;
            state <= START;
          end
        end

        START: begin
          start <= 1'b0;
          state <= WAIT_RES;
        end

        WAIT_RES: begin
          if (progress) begin
            res_data     <= ResultBus;
            res_zero     <= (ResultBus[30:0] == '0);
            res_inf      <= (ResultBus[30:23] == 8'hFF) && (ResultBus[22:0] == '0);
            res_nan      <= (ResultBus[30:23] == 8'hFF) && (ResultBus[22:0] != '0);
            resultaccept <= 1'b1;
            res_valid    <= 1'b1;
            state        <= ACK_RES;
          end
        end

        ACK_RES: begin
          if (progress) begin
            resultaccept <= 1'b0;
            req_ready    <= 1'b1;
            Tempbus      <= '0;
            state        <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase

      // Watchdog abort overrides whatever the state branch scheduled.
      if (abort) begin
        ready        <= 1'b0;
        start        <= 1'b0;
        resultaccept <= 1'b0;
        timeout_err  <= 1'b1;
        req_ready    <= 1'b1;
        Tempbus      <= '0;
        wd_cnt       <= '0;
        state        <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_fmul_operand_master.sv
// Testbench for fmul_operand_master: behavioural operand/result responders,
// a scoreboard of expected products consumed by an output monitor, and
// directed jobs covering nominal, handshake, watchdog, special-value and
// asynchronous reset cases.
module tb_fmul_operand_master;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_ready;
  logic [31:0] Tempbus;
  logic        ready;
  logic        accept;
  logic        start;
  logic        doneMul;
  logic        resultready;
  logic [31:0] ResultBus;
  logic        resultaccept;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_zero;
  logic        res_inf;
  logic        res_nan;
  logic        timeout_err;

  fmul_operand_master #(.TIMEOUT(TO), .TW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .Tempbus      (Tempbus),
    .ready        (ready),
    .accept       (accept),
    .start        (start),
    .doneMul      (doneMul),
    .resultready  (resultready),
    .ResultBus    (ResultBus),
    .resultaccept (resultaccept),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_zero     (res_zero),
    .res_inf      (res_inf),
    .res_nan      (res_nan),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        z;
    logic        i;
    logic        n;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] res_q[$];
  logic [31:0] ops_q[$];

  int checks = 0;
  int errors = 0;

  int acc_delay    = 2;
  int acc_hold     = 0;
  int res_delay    = 1;
  bit never_accept = 1'b0;

  int start_count = 0;
  int rise_count  = 0;
  int resv_count  = 0;
  bit saw_rr      = 1'b0;

  logic [31:0] op_seen;
  logic [31:0] res_val;
  logic        rp;
  logic        ap;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Operand responder: accepts after acc_delay cycles, holds accept for
  // acc_hold cycles after ready drops.
  initial begin : op_resp
    accept = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !ready || never_accept) continue;
      repeat (acc_delay) @(negedge clk);
      if (rst || !ready) continue;
      op_seen = Tempbus;
      ops_q.push_back(op_seen);
      accept = 1'b1;
      for (int k = 0; k < 64 && ready && !rst; k++) @(negedge clk);
      if (!rst && !ready) check32("tempbus_hold_in_release", Tempbus, op_seen);
      repeat (acc_hold) @(negedge clk);
      accept = 1'b0;
    end
  end

  // Result responder: answers a start pulse with the next queued product.
  initial begin : res_resp
    resultready = 1'b0;
    ResultBus   = '0;
    forever begin
      @(negedge clk);
      if (rst || !start || res_q.size() == 0) continue;
      res_val = res_q.pop_front();
      repeat (res_delay) @(negedge clk);
      ResultBus   = res_val;
      resultready = 1'b1;
      for (int k = 0; k < 64 && !resultaccept && !rst; k++) @(negedge clk);
      if (!rst) @(negedge clk);
      resultready = 1'b0;
      ResultBus   = '0;
    end
  end

  // Output monitor: handshake rule, event counters and scoreboard compare.
  initial begin : monitor
    exp_t e;
    rp = 1'b0;
    ap = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        rp = 1'b0;
        ap = accept;
        continue;
      end
      if (ready && !rp) begin
        rise_count++;
        check1("ready_rise_while_accept", ap, 1'b0);
      end
      rp = ready;
      ap = accept;
      if (start) start_count++;
      if (resultready) saw_rr = 1'b1;
      if (res_valid) begin
        resv_count++;
        if (exp_q.size() == 0) begin
          check1("res_valid_unexpected", res_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check32("res_data", res_data, e.data);
          check1("res_zero", res_zero, e.z);
          check1("res_inf", res_inf, e.i);
          check1("res_nan", res_nan, e.n);
        end
      end
    end
  end

  task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b);
    int k;
    k = 0;
    while (!req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) check1({tag, "_req_ready_wait"}, req_ready, 1'b1);
    ops_q.delete();
    start_count = 0;
    rise_count  = 0;
    saw_rr      = 1'b0;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check1({tag, "_req_ready_low"}, req_ready, 1'b0);
    check1({tag, "_timeout_err_clear"}, timeout_err, 1'b0);
  endtask

  task automatic finish_job(input string tag, input logic [31:0] a, input logic [31:0] b);
    int k;
    k = 0;
    while (!req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check1({tag, "_back_idle"}, req_ready, 1'b1);
    check1({tag, "_rr_low_at_idle"}, resultready, 1'b0);
    check1({tag, "_saw_resultready"}, saw_rr, 1'b1);
    check32({tag, "_start_pulses"}, start_count, 32'd1);
    check32({tag, "_ready_rises"}, rise_count, 32'd2);
    check32({tag, "_ops_count"}, 32'(ops_q.size()), 32'd2);
    if (ops_q.size() == 2) begin
      check32({tag, "_op_a"}, ops_q[0], a);
      check32({tag, "_op_b"}, ops_q[1], b);
    end
    check32({tag, "_tempbus_idle"}, Tempbus, 32'h0);
  endtask

  task automatic job(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] p, input logic z, input logic i, input logic n);
    exp_t e;
    e.data = p;
    e.z    = z;
    e.i    = i;
    e.n    = n;
    exp_q.push_back(e);
    res_q.push_back(p);
    issue(tag, a, b);
    finish_job(tag, a, b);
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_ready"}, ready, 1'b0);
    check1({tag, "_start"}, start, 1'b0);
    check1({tag, "_resultaccept"}, resultaccept, 1'b0);
    check1({tag, "_res_valid"}, res_valid, 1'b0);
    check32({tag, "_tempbus"}, Tempbus, 32'h0);
    check1({tag, "_req_ready"}, req_ready, 1'b0);
    check32({tag, "_res_data"}, res_data, 32'h0);
    check1({tag, "_timeout_err"}, timeout_err, 1'b0);
  endtask

  initial begin : guard
    #500000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1, "global timeout");
  end

  initial begin : main
    int k;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    doneMul   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check1("reset_flags", res_zero | res_inf | res_nan, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check1("req_ready_after_reset", req_ready, 1'b1);

    // Nominal job, 2-cycle accept delay.
    job("job1", 32'h41440000, 32'hC0600000, 32'hC22B8000, 1'b0, 1'b0, 1'b0);

    // Back-to-back job; result offered in the start cycle, doneMul toggled.
    res_delay = 0;
    doneMul   = 1'b1;
    job("job2", 32'h40100000, 32'h418C0000, 32'h421D8000, 1'b0, 1'b0, 1'b0);
    doneMul   = 1'b0;
    res_delay = 1;

    // accept held 5 cycles after ready drops.
    acc_delay = 0;
    acc_hold  = 5;
    job("hs", 32'h3F800000, 32'h40000000, 32'h40000000, 1'b0, 1'b0, 1'b0);
    acc_delay = 2;
    acc_hold  = 0;

    // Watchdog: no accept ever arrives.
    never_accept = 1'b1;
    issue("wd", 32'h3F800000, 32'h3F800000);
    check1("wd_ready_in_send_a", ready, 1'b1);
    k = 0;
    while (ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check32("wd_cycles_to_abort", k, TO);
    check1("wd_timeout_err", timeout_err, 1'b1);
    check1("wd_req_ready", req_ready, 1'b1);
    check32("wd_tempbus", Tempbus, 32'h0);
    check32("wd_no_start", start_count, 32'd0);
    never_accept = 1'b0;
    repeat (2) @(negedge clk);
    check1("wd_timeout_err_sticky", timeout_err, 1'b1);
    job("after_wd", 32'h40400000, 32'h40800000, 32'h41400000, 1'b0, 1'b0, 1'b0);

    // Special results.
    job("inf",  32'h7F000000, 32'h40000000, 32'h7F800000, 1'b0, 1'b1, 1'b0);
    job("nan",  32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0, 1'b1);
    job("zero", 32'h80000000, 32'h3F800000, 32'h80000000, 1'b1, 1'b0, 1'b0);

    // Async reset in WAIT_RES (no result queued, so none is offered).
    issue("rst_wait", 32'h40400000, 32'h40400000);
    k = 0;
    while (!start && k < 100) begin
      @(negedge clk);
      k++;
    end
    check1("rst_wait_saw_start", start, 1'b1);
    @(negedge clk);
    check32("rst_wait_tempbus_b", Tempbus, 32'h40400000);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check1("rst_wait_req_ready", req_ready, 1'b1);

    // Async reset in SEND_B.
    issue("rst_sendb", 32'h40A00000, 32'h40C00000);
    k = 0;
    while (!(ready && Tempbus == 32'h40C00000) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check32("rst_sendb_in_send_b", Tempbus, 32'h40C00000);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_sendb");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check1("rst_sendb_req_ready", req_ready, 1'b1);

    // Fresh job after reset.
    job("post_rst", 32'h40A00000, 32'h40C00000, 32'h41F00000, 1'b0, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    check32("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check32("res_valid_total", resv_count, 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
